dmem_sized: RTL and testbench



---
 rtl/dmem_sized_if.sv | 32 +++
 rtl/dmem_sized.sv | 232 +++++++++++++++++++++++
 tb/tb_dmem_sized.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_sized_if.sv
`default_nettype none
// ============================================================================
//  Module  : dmem_sized_if
//  Brief   : Request/response bundle between the load/store stage (master)
//            and the sized data memory (slave).
//  Rev     : 1.0  initial release
// ============================================================================
interface dmem_sized_if #(
  parameter int ADDR_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/dmem_sized.sv
`default_nettype none
// ============================================================================
//  Module  : dmem_sized
//  Brief   : Word-organised data RAM with valid/ready request port, one-cycle
//            response pulse and LATENCY wait states. Byte/half/word access,
//            little-endian lanes, sign/zero-extended loads, error flag for
//            out-of-range and reserved-size accesses.
//  Option  : DMEM_MISALIGN_TRAP_EN - misaligned half/word accesses raise
//            rsp_err instead of being forced to natural alignment.
//  Rev     : 1.0  initial release
// ============================================================================
module dmem_sized #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 32,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  dmem_sized_if.slave bus
);

  localparam int         IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] LAT_M1  = 4'(LATENCY - 1);
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;

  logic              we_q, uns_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic [31:0]       rsp_rdata_q;
  logic              rsp_err_q;

  logic [31:0]       mem_q [DEPTH_WORDS];

  // Access fields: with zero wait states the access happens on the very edge
  // that accepts the request, so the live bus is used while still in IDLE.
  logic              from_bus;
  logic              cur_we, cur_uns;
  logic [1:0]        cur_size;
  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       cur_wdata;

  logic [ADDR_W-3:0] word_idx;
  logic [IDX_W-1:0]  word_sel;
  logic              in_range;
  logic              misalign_err;
  logic              acc_err;
  logic [1:0]        lane;
  logic [31:0]       mem_word;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_data;
  logic [3:0]        be;
  logic [31:0]       wd;
  logic              enter_resp;
  logic              wr_en;

  assign from_bus  = (state_q == S_IDLE);
  assign cur_we    = from_bus ? bus.req_we       : we_q;
  assign cur_uns   = from_bus ? bus.req_unsigned : uns_q;
  assign cur_size  = from_bus ? bus.req_size     : size_q;
  assign cur_addr  = from_bus ? bus.req_addr     : addr_q;
  assign cur_wdata = from_bus ? bus.req_wdata    : wdata_q;

  // Full-width index compare: addresses beyond the array never wrap.
  assign word_idx = cur_addr[ADDR_W-1:2];
  assign word_sel = word_idx[IDX_W-1:0];
  assign in_range = (64'(word_idx) < 64'(DEPTH_WORDS));

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign_err = ((cur_size == SZ_HALF) && cur_addr[0]) ||
                        ((cur_size == SZ_WORD) && (cur_addr[1:0] != 2'b00));
  assign lane         = cur_addr[1:0];
`else
  assign misalign_err = 1'b0;
  // Force natural alignment by dropping the low offset bits.
  always_comb begin
    lane = cur_addr[1:0];
    case (cur_size)
      SZ_HALF: lane = {cur_addr[1], 1'b0};
      SZ_WORD: lane = 2'b00;
      default: lane = cur_addr[1:0];
    endcase
  end
`endif

  assign acc_err  = !in_range || (cur_size == 2'b11) || misalign_err;
  assign mem_word = mem_q[word_sel];
  assign ld_byte  = mem_word[{lane, 3'b000} +: 8];
  assign ld_half  = mem_word[{lane[1], 4'b0000} +: 16];

  // Extend the selected lanes; errors and stores return zero.
  always_comb begin
    ld_data = 32'h0;
    if (!acc_err && !cur_we) begin
      case (cur_size)
        SZ_BYTE: ld_data = cur_uns ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
        SZ_HALF: ld_data = cur_uns ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
        SZ_WORD: ld_data = mem_word;
        default: ld_data = 32'h0;
      endcase
    end
  end

  // Byte enables and lane-replicated store data.
  always_comb begin
    be = 4'b0000;
    wd = 32'h0;
    case (cur_size)
      SZ_BYTE: begin
        be = 4'b0001 << lane;
        wd = {4{cur_wdata[7:0]}};
      end
      SZ_HALF: begin
        be = lane[1] ? 4'b1100 : 4'b0011;
        wd = {2{cur_wdata[15:0]}};
      end
      SZ_WORD: begin
        be = 4'b1111;
        wd = cur_wdata;
      end
      default: begin
        be = 4'b0000;
        wd = 32'h0;
      end
    endcase
  end

  // Next state and wait counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = 4'd0;
        if (bus.req_valid) begin
          state_d = (LATENCY > 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        if (cnt_q == LAT_M1) begin
          cnt_d   = 4'd0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RESP: begin
        cnt_d   = 4'd0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = 4'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  // The RAM access point is the edge that enters RESP; reset blocks it.
  assign enter_resp = (state_d == S_RESP);
  assign wr_en      = rst_n && enter_resp && cur_we && !acc_err;

  // State register and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the request on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= 32'h0;
    end else if (from_bus && bus.req_valid) begin
      we_q    <= bus.req_we;
      uns_q   <= bus.req_unsigned;
      size_q  <= bus.req_size;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
    end
  end

  // Response data/error are valid only during the RESP cycle, zero otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else if (enter_resp) begin
      rsp_rdata_q <= ld_data;
      rsp_err_q   <= acc_err;
    end else begin
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end
  end

  // RAM write, lane-masked; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[word_sel][8*b +: 8] <= wd[8*b +: 8];
      end
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_sized.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : tb_dmem_sized
//  Brief   : Bench for dmem_sized. Four instances with LATENCY 1, 0, 5, 4
//            checked against a byte-addressed reference memory.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_dmem_sized;

  localparam int NDUT  = 4;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NDUT-1:0]       rst_n, valid, we, uns;
  logic [NDUT-1:0][1:0]  size;
  logic [NDUT-1:0][31:0] addr, wdata;
  logic [NDUT-1:0]       ready, rvalid, rerr;
  logic [NDUT-1:0][31:0] rdata;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 5 : 4;
    dmem_sized_if #(.ADDR_W(32)) bus ();
    dmem_sized #(.DEPTH_WORDS(DEPTH), .ADDR_W(32), .LATENCY(LAT)) u_dut (
      .clk   (clk),
      .rst_n (rst_n[g]),
      .bus   (bus.slave)
    );
    assign bus.req_valid    = valid[g];
    assign bus.req_we       = we[g];
    assign bus.req_size     = size[g];
    assign bus.req_unsigned = uns[g];
    assign bus.req_addr     = addr[g];
    assign bus.req_wdata    = wdata[g];
    assign ready[g]         = bus.req_ready;
    assign rvalid[g]        = bus.rsp_valid;
    assign rdata[g]         = bus.rsp_rdata;
    assign rerr[g]          = bus.rsp_err;
  end

  function automatic int lat_of(input int s);
    case (s)
      0: return 1;
      1: return 0;
      2: return 5;
      default: return 4;
    endcase
  endfunction

  // Reference: plain byte-addressed memory per instance.
  logic [7:0] mem_m [NDUT][DEPTH*4];

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=%08h expected=%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Apply one access to the reference and return what the memory must answer.
  task automatic model_access(input int s, input logic w, input logic [1:0] sz,
                              input logic u, input logic [31:0] a, input logic [31:0] wdv,
                              output logic [31:0] exp_rd, output logic exp_err);
    int nb;
    logic [31:0] ea, v;
    exp_rd  = 32'h0;
    exp_err = 1'b0;
    ea      = a;
    nb      = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    if (sz == 2'd3) exp_err = 1'b1;
    else if (a >= 32'(DEPTH*4)) exp_err = 1'b1;
    else if ((a % nb) != 0) begin
`ifdef DMEM_MISALIGN_TRAP_EN
      exp_err = 1'b1;
`else
      ea = a - (a % nb);
`endif
    end
    if (!exp_err) begin
      if (w) begin
        for (int i = 0; i < nb; i++) mem_m[s][ea+i] = wdv[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = mem_m[s][ea+i];
        if (!u && nb < 4 && v[8*nb-1]) begin
          for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
        end
        exp_rd = v;
      end
    end
  endtask

  // Full transaction: present, wait for acceptance, check latency and response.
  task automatic do_access(input int s, input logic w, input logic [1:0] sz, input logic u,
                           input logic [31:0] a, input logic [31:0] wdv, input string tag);
    logic [31:0] er;
    logic        ee;
    bit          acc;
    int          k;
    valid[s] = 1'b1; we[s] = w; size[s] = sz; uns[s] = u; addr[s] = a; wdata[s] = wdv;
    acc = 1'b0;
    for (int t = 0; t < 20 && !acc; t++) begin
      @(negedge clk);
      acc = ready[s];
      @(posedge clk);
    end
    #1 valid[s] = 1'b0;
    if (!acc) begin
      check({tag, " accept timeout"}, 32'd0, 32'd1);
      return;
    end
    model_access(s, w, sz, u, a, wdv, er, ee);
    k = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      k++;
      if (rvalid[s]) break;
    end
    check({tag, " latency"}, 32'(k), 32'(lat_of(s) + 1));
    check({tag, " rdata"}, rdata[s], er);
    check({tag, " err"}, 32'(rerr[s]), 32'(ee));
    @(negedge clk);
    check({tag, " pulse end"}, {rdata[s][30:0], rvalid[s]}, 32'h0);
    @(posedge clk);
    #1;
  endtask

  // Continuous req_valid with a new store address every cycle.
  task automatic stream(input int s, input int n, input logic [31:0] base);
    logic [31:0] er;
    logic        ee;
    bit          acc;
    int          last, nacc;
    last = -1; nacc = 0;
    valid[s] = 1'b1; we[s] = 1'b1; size[s] = 2'd2; uns[s] = 1'b0;
    addr[s] = base; wdata[s] = 32'hA5000000;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      acc = ready[s];
      @(posedge clk);
      if (acc) begin
        model_access(s, 1'b1, 2'd2, 1'b0, addr[s], wdata[s], er, ee);
        if (last >= 0) check($sformatf("gap s%0d", s), 32'(c - last), 32'(lat_of(s) + 2));
        last = c;
        nacc++;
      end
      #1;
      addr[s]  = base + 32'(4 * (c + 1));
      wdata[s] = 32'hA5000000 | 32'(c + 1);
    end
    valid[s] = 1'b0;
    check($sformatf("accepts s%0d", s), 32'(nacc), 32'((n + lat_of(s) + 1) / (lat_of(s) + 2)));
    repeat (lat_of(s) + 3) @(posedge clk);
    #1;
    for (int c = 0; c < n; c++) begin
      do_access(s, 1'b0, 2'd2, 1'b0, base + 32'(4 * c), 32'h0, $sformatf("stream rd s%0d", s));
    end
  endtask

  task automatic rand_ops(input int s, input int n);
    logic [31:0] a;
    logic [1:0]  sz;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 9))
        0:       a = 32'(DEPTH*4) + $urandom_range(0, 255);
        1:       a = $urandom | 32'h8000_0000;
        default: a = $urandom_range(0, 63);
      endcase
      sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      do_access(s, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
                $sformatf("rand s%0d #%0d", s, i));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int s = 0; s < NDUT; s++) for (int i = 0; i < DEPTH*4; i++) mem_m[s][i] = 8'h00;
    rst_n = '0; valid = '0; we = '0; uns = '0; size = '0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = '1;
    @(negedge clk);
    check("reset ready", 32'(ready), 32'hF);
    check("reset rsp_valid", 32'(rvalid), 32'h0);
    check("reset rsp_err", 32'(rerr), 32'h0);
    check("reset rdata0", rdata[0], 32'h0);
    @(posedge clk);
    #1;

    do_access(0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, "zero init");

    do_access(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, "merge st w");
    do_access(0, 1'b1, 2'd0, 1'b0, 32'h12, 32'h000000AB, "merge st b");
    do_access(0, 1'b1, 2'd1, 1'b0, 32'h10, 32'h0000BEEF, "merge st h");
    do_access(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "merge ld w");
    check("merge model", {mem_m[0][19], mem_m[0][18], mem_m[0][17], mem_m[0][16]}, 32'h11ABBEEF);

    do_access(0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h000080F0, "ext st");
    do_access(0, 1'b0, 2'd0, 1'b0, 32'h20, 32'h0, "ext sb");
    do_access(0, 1'b0, 2'd0, 1'b1, 32'h20, 32'h0, "ext ub");
    do_access(0, 1'b0, 2'd1, 1'b0, 32'h20, 32'h0, "ext sh");
    do_access(0, 1'b0, 2'd1, 1'b1, 32'h22, 32'h0, "ext uh");

    do_access(0, 1'b1, 2'd2, 1'b0, 32'(DEPTH*4), 32'hCAFEF00D, "err range st");
    do_access(0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, "err range loc0");
    do_access(0, 1'b1, 2'd3, 1'b0, 32'h10, 32'h55555555, "err size st");
    do_access(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "err size chk");
    do_access(0, 1'b0, 2'd2, 1'b0, 32'h21, 32'h0, "misalign ld w");
    do_access(0, 1'b0, 2'd1, 1'b0, 32'h23, 32'h0, "misalign ld h");

    stream(1, 12, 32'h100);
    stream(2, 22, 32'h200);

    do_access(3, 1'b1, 2'd2, 1'b0, 32'h40, 32'h12345678, "rst pre st");
    valid[3] = 1'b1; we[3] = 1'b1; size[3] = 2'd2; addr[3] = 32'h40; wdata[3] = 32'hDEADBEEF;
    @(negedge clk);
    check("rst accept ready", 32'(ready[3]), 32'h1);
    @(posedge clk);
    #1 valid[3] = 1'b0;
    @(negedge clk);
    check("rst in wait", 32'(ready[3]), 32'h0);
    @(negedge clk);
    rst_n[3] = 1'b0;
    #1;
    check("rst ready async", 32'(ready[3]), 32'h1);
    check("rst rsp_valid", 32'(rvalid[3]), 32'h0);
    @(negedge clk);
    rst_n[3] = 1'b1;
    @(posedge clk);
    #1;
    do_access(3, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, "rst dropped st");

    rand_ops(0, 80);
    rand_ops(1, 30);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
